// File: rtl/div_arbiter_if.sv
// Bundle of requester-side and divider-side signals around the shared-divider arbiter.
// The arbiter uses the slave modport; requesters plus the divider use master.
interface div_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]   i_req;
  logic [N*W-1:0] i_dividend;
  logic [N*W-1:0] i_divisor;
  logic [N-1:0]   o_gnt;
  logic [N-1:0]   o_done;
  logic [W-1:0]   o_quotient;
  logic [W-1:0]   o_remainder;
  logic           o_dbz;
  logic           o_err;
  logic [W-1:0]   o_div_dividend;
  logic [W-1:0]   o_div_divisor;
  logic           o_div_start;
  logic           i_div_ready;
  logic [W-1:0]   i_div_quotient;
  logic [W-1:0]   i_div_remainder;

  modport slave (
    input  i_req, i_dividend, i_divisor, i_div_ready, i_div_quotient, i_div_remainder,
    output o_gnt, o_done, o_quotient, o_remainder, o_dbz, o_err,
           o_div_dividend, o_div_divisor, o_div_start
  );

  modport master (
    output i_req, i_dividend, i_divisor, i_div_ready, i_div_quotient, i_div_remainder,
    input  o_gnt, o_done, o_quotient, o_remainder, o_dbz, o_err,
           o_div_dividend, o_div_divisor, o_div_start
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider among N requesters, with
// divide-by-zero short-circuit and a timeout on the divider ready handshake.
module div_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input logic          i_clk,
  input logic          i_rst,
  div_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   gnt;
  logic [IW-1:0]  gnt_idx;
  logic [IW-1:0]  ptr;
  logic [W-1:0]   dvd, dvs, quo, rem;
  logic           dbz, err;
  logic [CW-1:0]  cnt;

  logic           pick_vld;
  logic [IW-1:0]  pick_idx;
  logic [W-1:0]   pick_dvd, pick_dvs;
  logic           accept, expire;

  // Round-robin: first set request at or after ptr, wrapping.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!pick_vld && bus.i_req[(int'(ptr) + i) % N]) begin
        pick_vld = 1'b1;
        pick_idx = IW'((int'(ptr) + i) % N);
      end
    end
  end

  assign pick_dvd = bus.i_dividend[int'(pick_idx) * W +: W];
  assign pick_dvs = bus.i_divisor[int'(pick_idx) * W +: W];

  // The first WAIT cycle (cnt == 0) ignores ready; a late ready still beats the timeout.
  assign accept = (state == WAIT) && (cnt != '0) && bus.i_div_ready;
  assign expire = (state == WAIT) && !accept && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_vld) state_nx = (pick_dvs == '0) ? RESP : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (accept || expire) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: operand and result registers are reset too, because reset must force every output to zero.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      quo     <= '0;
      rem     <= '0;
      dbz     <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt     <= N'(1) << pick_idx;
            gnt_idx <= pick_idx;
            dvd     <= pick_dvd;
            dvs     <= pick_dvs;
            err     <= 1'b0;
            dbz     <= (pick_dvs == '0);
            if (pick_dvs == '0) begin
              quo <= '1;
              rem <= pick_dvd;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (accept) begin
            quo <= bus.i_div_quotient;
            rem <= bus.i_div_remainder;
          end else if (expire) begin
            quo <= '0;
            rem <= '0;
            err <= 1'b1;
          end
        end
        RESP: begin
          gnt <= '0;
          cnt <= '0;
          ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_gnt          = gnt;
  assign bus.o_done         = (state == RESP) ? gnt : '0;
  assign bus.o_quotient     = quo;
  assign bus.o_remainder    = rem;
  assign bus.o_dbz          = dbz;
  assign bus.o_err          = err;
  assign bus.o_div_dividend = dvd;
  assign bus.o_div_divisor  = dvs;
  assign bus.o_div_start    = (state == ISSUE);
endmodule
